maxpool_reducer: RTL and testbench
==================================

MAXPOOL_REDUCER -- requirements
Module: maxpool_reducer

Interface
REQ-001 Parameter WINDOW, default 4: elements per pooling window; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream beat valid.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 in_data  input  32  IEEE-754 single-precision element.
REQ-007 in_last  input  1  closes the current window early; sampled only on an accepted beat.
REQ-008 out_valid  output  1  pooled result valid.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_data  output  32  IEEE-754 maximum of the window.
REQ-011 out_count  output  5  number of elements reduced into out_data (1..WINDOW).

Function
REQ-012 A beat is accepted when in_valid && in_ready; a result is transferred when out_valid && out_ready.
REQ-013 in_ready shall equal (!out_valid || out_ready); it shall have no combinational dependence on in_valid.
REQ-014 The FSM has states EMPTY (cnt==0) and ACCUM (0<cnt<WINDOW).
REQ-015 EMPTY, on an accepted beat: acc <= in_data; cnt <= 1; go to ACCUM, unless the beat closes the window.
REQ-016 ACCUM, on an accepted beat: acc <= fp32max(acc, in_data); cnt <= cnt+1.
REQ-017 A beat closes the window when in_last==1 or cnt==WINDOW-1; closing conditions:
- out_data <= the reduced value including that beat
- out_count <= cnt+1
- out_valid <= 1
- cnt <= 0, go to EMPTY
REQ-018 Latency: out_valid rises on the clock edge that accepts the closing beat; a result is visible the cycle after that beat.
REQ-019 A result transfer and a new closing beat in the same cycle shall load the new result and keep out_valid=1; no result is dropped.
REQ-020 A result transfer with no new closing beat clears out_valid.
REQ-021 While out_valid && !out_ready, out_data and out_count shall hold stable, and no beat is accepted.
REQ-022 fp32max ordering: by sign, then by exponent and mantissa magnitude; for negative values the larger magnitude is smaller.
REQ-023 fp32max on zeros: +0 (0x00000000) is greater than -0 (0x80000000).
REQ-024 NaN handling:
- Any NaN operand (exp==0xFF, mantissa!=0) yields canonical 0x7FC00000.
- NaN is sticky for the rest of the window.
REQ-025 Infinities and subnormals are ordered as ordinary values under REQ-022.
REQ-026 in_last on the first beat of a window yields out_data=in_data and out_count=1; a NaN first beat yields 0x7FC00000.

Reset
REQ-027 Asserting rst_n low shall immediately force the following values:
- out_valid=0, out_data=0, out_count=0
- cnt=0, acc=0, state=EMPTY
REQ-028 Reset mid-window discards the partial window; the first beat accepted after release starts a new window.
REQ-029 in_ready shall be 1 during and immediately after reset.

Structure
REQ-030 A shared package tpu_pkg holds:
- the fp32 typedef (sign, exp[7:0], mant[22:0])
- FP32_QNAN = 32'h7FC00000
- the FSM state enum
REQ-031 The comparison is a combinational sub-module fp32_max (a, b -> y) implementing REQ-022..REQ-025; it is instantiated once.
REQ-032 out_count width is fixed at 5 bits for all legal WINDOW values.

Verification
REQ-033 WINDOW=4, beats 3.5, 2.5, -40.0, 40.0, out_ready=1 -> out_data=0x42200000 (40.0), out_count=4, one cycle after the 4th beat.
REQ-034 Beats -3.5, -2.5, -7.0, -1000.0 -> out_data=0xC0200000 (-2.5).
REQ-035 Beats -0.0, then +0.0 with in_last=1 -> out_data=0x00000000, out_count=2; next window starts fresh.
REQ-036 Beats 1.0, 0x7FC00001, 2.0, 3.0 -> out_data=0x7FC00000.
REQ-037 Backpressure: close a window, hold out_ready=0 for 5 cycles with in_valid=1:
- in_ready=0 throughout; out_data is unchanged.
- After out_ready rises, windows continue back-to-back with no beat lost or duplicated.
REQ-038 rst_n pulsed low after 2 beats of a window:
- out_valid drops immediately.
- The next 4 beats 1.0, 2.0, 3.0, 4.0 -> out_data=0x40800000, out_count=4.

Source files
------------

// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Shared types and constants for the pooling datapath.
//   fp32_t     : IEEE-754 single-precision fields (sign, exp, mant)
//   FP32_QNAN  : canonical quiet NaN returned whenever a NaN is seen
//   state_e    : reducer FSM states (EMPTY = no partial window held,
//                ACCUM = a partial window is being reduced)
// ---------------------------------------------------------------------------
package tpu_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } fp32_t;

   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_ACCUM = 1'b1
   } state_e;

endpackage

// File: rtl/fp32_max.sv
// ---------------------------------------------------------------------------
// fp32_max
// Combinational maximum of two IEEE-754 single-precision values.
//   a, b : operands
//   y    : the larger operand, or FP32_QNAN if either operand is a NaN
// Ordering is total over non-NaN values: +0 is above -0, infinities and
// subnormals are ordered like any other value.
// ---------------------------------------------------------------------------
module fp32_max
   import tpu_pkg::*;
(
   input  fp32_t a,
   input  fp32_t b,
   output fp32_t y
);

   logic        aNaN;
   logic        bNaN;
   logic [31:0] keyA;
   logic [31:0] keyB;

   // Map each value onto an unsigned key whose integer order matches the
   // floating-point order: positives get the top bit set so they sit above
   // all negatives, and negatives are bit-inverted so a larger magnitude
   // gives a smaller key. This also places -0 directly below +0.
   always_comb begin
      aNaN = (a.exp == 8'hFF) && (a.mant != 23'd0);
      bNaN = (b.exp == 8'hFF) && (b.mant != 23'd0);
      keyA = a.sign ? ~a : {1'b1, a[30:0]};
      keyB = b.sign ? ~b : {1'b1, b[30:0]};
      if (aNaN || bNaN) begin
         y = FP32_QNAN;
      end else if (keyA >= keyB) begin
         y = a;
      end else begin
         y = b;
      end
   end

endmodule

// File: rtl/maxpool_reducer.sv
// ---------------------------------------------------------------------------
// maxpool_reducer
// Streams fp32 elements in, reduces each window of up to WINDOW elements to
// its maximum and presents one result per window.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   in_valid / in_ready             : element handshake
//   in_data                         : fp32 element
//   in_last                         : closes the current window early
//   out_valid / out_ready           : result handshake
//   out_data                        : fp32 maximum of the window
//   out_count                       : number of elements in that window
// ---------------------------------------------------------------------------
module maxpool_reducer
   import tpu_pkg::*;
#(
   parameter int WINDOW = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_count
);

   localparam logic [4:0] LAST_IDX = 5'(WINDOW - 1);

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] acc_q, acc_d;
   logic        outValid_q, outValid_d;
   logic [31:0] outData_q, outData_d;
   logic [4:0]  outCount_q, outCount_d;

   logic        acceptBeat;
   logic        closeBeat;
   fp32_t       maxA;
   fp32_t       maxY;

   // A result slot frees up either when it is empty or when it is being
   // taken this cycle, so acceptance never waits on in_valid.
   assign in_ready   = !outValid_q || out_ready;
   assign acceptBeat = in_valid && in_ready;
   assign closeBeat  = in_last || (cnt_q == LAST_IDX);

   // On the first beat of a window the element is compared with itself,
   // which returns it unchanged or canonicalises a NaN, so one comparator
   // covers both the start and the continuation of a window. A NaN held in
   // the accumulator forces every later comparison to NaN, keeping it sticky.
   assign maxA = (state_q == ST_EMPTY) ? fp32_t'(in_data) : fp32_t'(acc_q);

   fp32_max u_max (
      .a (maxA),
      .b (fp32_t'(in_data)),
      .y (maxY)
   );

   // Next-state logic: take the pending result away when downstream accepts
   // it, then fold an accepted beat into the window. A closing beat loads the
   // result register directly, which also covers a same-cycle transfer and
   // close without dropping anything.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outCount_d = outCount_q;

      if (outValid_q && out_ready) begin
         outValid_d = 1'b0;
      end

      if (acceptBeat) begin
         if (closeBeat) begin
            outData_d  = maxY;
            outCount_d = 5'(cnt_q + 5'd1);
            outValid_d = 1'b1;
            cnt_d      = 5'd0;
            state_d    = ST_EMPTY;
         end else begin
            acc_d   = maxY;
            cnt_d   = 5'(cnt_q + 5'd1);
            state_d = ST_ACCUM;
         end
      end
   end

   // State registers; reset discards any partial window and pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         cnt_q      <= 5'd0;
         acc_q      <= 32'd0;
         outValid_q <= 1'b0;
         outData_q  <= 32'd0;
         outCount_q <= 5'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outCount_q <= outCount_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_count = outCount_q;

endmodule

// File: tb/tb_maxpool_reducer.sv
// ---------------------------------------------------------------------------
// tb_maxpool_reducer
// Self-checking bench for maxpool_reducer (WINDOW = 4): directed windows with
// literal expectations, then randomized traffic compared every cycle against
// a window-list model that works on real-valued element magnitudes.
// ---------------------------------------------------------------------------
module tb_maxpool_reducer;

   localparam int WINDOW = 4;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_count;

   int nChecks = 0;
   int nFails  = 0;

   logic [31:0] winQ[$];
   logic        expValid = 1'b0;
   logic [31:0] expData  = 32'd0;
   logic [4:0]  expCount = 5'd0;

   maxpool_reducer #(.WINDOW(WINDOW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: every check funnels through here so the
   // counters in the summary line are exactly what the checks stepped.
   task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Real value of an fp32 pattern; infinities become a huge finite magnitude,
   // which is enough to order them above every finite value.
   function automatic real toReal(input logic [31:0] v);
      real mag;
      int  e;
      e = int'(v[30:23]);
      if (e == 255)
         mag = 1.0e300;
      else if (e == 0)
         mag = real'(v[22:0]) * (2.0 ** (-149.0));
      else
         mag = (1.0 + real'(v[22:0]) / 8388608.0) * (2.0 ** (real'(e) - 127.0));
      return v[31] ? -mag : mag;
   endfunction

   function automatic logic isNaN(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   // Reference maximum: NaN dominates, otherwise the numerically larger value,
   // and between the two zeros the positive one wins.
   function automatic logic [31:0] refMax(input logic [31:0] a, input logic [31:0] b);
      real ra;
      real rb;
      if (isNaN(a) || isNaN(b)) return QNAN;
      ra = toReal(a);
      rb = toReal(b);
      if (ra > rb) return a;
      if (rb > ra) return b;
      return a[31] ? b : a;
   endfunction

   // Behavioural model: collect accepted elements into a list and, when the
   // window closes, fold the list with refMax into the expected result.
   initial begin
      logic        modelReady;
      logic [31:0] acc;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            winQ.delete();
            expValid = 1'b0;
            expData  = 32'd0;
            expCount = 5'd0;
         end else begin
            modelReady = !expValid || out_ready;
            if (expValid && out_ready) expValid = 1'b0;
            if (in_valid && modelReady) begin
               winQ.push_back(in_data);
               if (in_last || winQ.size() == WINDOW) begin
                  acc = refMax(winQ[0], winQ[0]);
                  for (int i = 1; i < winQ.size(); i++) acc = refMax(acc, winQ[i]);
                  expData  = acc;
                  expCount = 5'(winQ.size());
                  expValid = 1'b1;
                  winQ.delete();
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         checkEq("cyc_out_valid", {31'd0, out_valid}, {31'd0, expValid});
         checkEq("cyc_in_ready",  {31'd0, in_ready},  {31'd0, (!expValid || out_ready)});
         checkEq("cyc_out_data",  out_data, expData);
         checkEq("cyc_out_count", {27'd0, out_count}, {27'd0, expCount});
      end
   end

   // Drive one beat and let one active edge pass; returns just after it.
   task automatic applyStimulus(input logic [31:0] data, input logic last);
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Literal expectation for a result that must be on the outputs now.
   task automatic checkOutput(input string name, input logic [31:0] data, input logic [4:0] count);
      checkEq({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      checkEq({name, "_data"},  out_data, data);
      checkEq({name, "_count"}, {27'd0, out_count}, {27'd0, count});
   endtask

   function automatic logic [31:0] randElem();
      logic [31:0] specials [9];
      logic [31:0] v;
      specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                   32'h7FC0_0000, 32'hFFC0_0001, 32'h0000_0001, 32'h8000_0001,
                   32'h7F7F_FFFF};
      case ($urandom_range(7))
         0: v = $urandom;
         1: v = specials[$urandom_range(8)];
         default: v = {1'($urandom_range(1)), 8'(126 + $urandom_range(3)),
                       3'($urandom_range(7)), 20'd0};
      endcase
      return v;
   endfunction

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset values while reset is held.
      #1;
      checkEq("rst_in_ready",  {31'd0, in_ready},  32'd1);
      checkEq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkEq("rst_out_data",  out_data, 32'd0);
      checkEq("rst_out_count", {27'd0, out_count}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkEq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Pin the reference maximum itself to hand-computed values.
      checkEq("pin_zero",   refMax(32'h8000_0000, 32'h0000_0000), 32'h0000_0000);
      checkEq("pin_neg",    refMax(32'hC060_0000, 32'hC020_0000), 32'hC020_0000);
      checkEq("pin_inf",    refMax(32'h7F7F_FFFF, 32'h7F80_0000), 32'h7F80_0000);
      checkEq("pin_subn",   refMax(32'h8000_0001, 32'h0000_0001), 32'h0000_0001);
      checkEq("pin_nan",    refMax(32'h3F80_0000, 32'hFFC0_0001), QNAN);

      // Mixed-sign full window.
      applyStimulus(32'h4060_0000, 1'b0);
      applyStimulus(32'h4020_0000, 1'b0);
      applyStimulus(32'hC220_0000, 1'b0);
      applyStimulus(32'h4220_0000, 1'b0);
      checkOutput("w_mixed", 32'h4220_0000, 5'd4);

      // All negative: smallest magnitude wins.
      applyStimulus(32'hC060_0000, 1'b0);
      applyStimulus(32'hC020_0000, 1'b0);
      applyStimulus(32'hC0E0_0000, 1'b0);
      applyStimulus(32'hC47A_0000, 1'b0);
      checkOutput("w_neg", 32'hC020_0000, 5'd4);

      // Signed zeros with early close, then a fresh one-element window.
      applyStimulus(32'h8000_0000, 1'b0);
      applyStimulus(32'h0000_0000, 1'b1);
      checkOutput("w_zero", 32'h0000_0000, 5'd2);
      applyStimulus(32'h3F80_0000, 1'b1);
      checkOutput("w_fresh", 32'h3F80_0000, 5'd1);

      // NaN in the middle is sticky.
      applyStimulus(32'h3F80_0000, 1'b0);
      applyStimulus(32'h7FC0_0001, 1'b0);
      applyStimulus(32'h4000_0000, 1'b0);
      applyStimulus(32'h4040_0000, 1'b0);
      checkOutput("w_nan", QNAN, 5'd4);

      // NaN as sole element is canonicalised.
      applyStimulus(32'h7FF0_0001, 1'b1);
      checkOutput("w_nan_first", QNAN, 5'd1);

      // Backpressure: hold the result for 5 cycles with a beat waiting.
      applyStimulus(32'h3F80_0000, 1'b0);
      applyStimulus(32'h4000_0000, 1'b0);
      applyStimulus(32'h4040_0000, 1'b1);
      checkOutput("w_bp", 32'h4040_0000, 5'd3);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h40A0_0000;
      in_last   = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         checkEq("bp_in_ready", {31'd0, in_ready}, 32'd0);
         checkEq("bp_out_data", out_data, 32'h4040_0000);
      end
      out_ready = 1'b1;
      applyStimulus(32'h40A0_0000, 1'b0);
      applyStimulus(32'h40C0_0000, 1'b0);
      applyStimulus(32'h40E0_0000, 1'b0);
      applyStimulus(32'h4100_0000, 1'b0);
      checkOutput("w_bp_next", 32'h4100_0000, 5'd4);
      applyStimulus(32'h3F80_0000, 1'b0);
      applyStimulus(32'h4000_0000, 1'b0);
      applyStimulus(32'h4040_0000, 1'b0);
      applyStimulus(32'h4080_0000, 1'b0);
      checkOutput("w_bp_next2", 32'h4080_0000, 5'd4);

      // Reset with a pending result drops out_valid without a clock edge.
      applyStimulus(32'h4110_0000, 1'b1);
      out_ready = 1'b0;
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      checkEq("arst_out_valid", {31'd0, out_valid}, 32'd0);
      checkEq("arst_out_data",  out_data, 32'd0);
      checkEq("arst_in_ready",  {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // Reset after two beats discards the partial window.
      applyStimulus(32'h4220_0000, 1'b0);
      applyStimulus(32'h4220_0000, 1'b0);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      checkEq("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(32'h3F80_0000, 1'b0);
      applyStimulus(32'h4000_0000, 1'b0);
      applyStimulus(32'h4040_0000, 1'b0);
      applyStimulus(32'h4080_0000, 1'b0);
      checkOutput("w_after_rst", 32'h4080_0000, 5'd4);

      // Randomized traffic with random backpressure; the model checks it all.
      for (int n = 0; n < 4000; n++) begin
         in_valid  = ($urandom_range(3) != 0);
         in_last   = ($urandom_range(5) == 0);
         in_data   = randElem();
         out_ready = ($urandom_range(2) != 0);
         @(posedge clk);
         #1;
      end

      idle();
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
